// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: frame FSM states, parity-mode codes and
// bit-period divider helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned baud_cnt_width(input int unsigned clk_hz, input int unsigned baud);
        int unsigned div;
        div = clk_hz / baud;
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts DIV clocks while enabled and pulses o_tick on the
// last clock of each period; i_restart holds the count at zero.
module uart_baud_tick #(
    parameter int unsigned DIV = 5208,
    parameter int unsigned CW  = 13
) (
    input  logic clk_50M,
    input  logic reset_n,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tick
);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start / data (LSB first) / optional parity / stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry queue in front of the shifter.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk_50M,
    input  logic                 reset_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 uart_txd
);

    localparam int unsigned DIV       = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CW        = baud_cnt_width(CLK_HZ, BAUD);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_t          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_load_data;
    logic [3:0]           r_bitcnt;
    logic                 r_par, r_rst_done;
    logic                 w_tick, w_ready, w_push, w_avail, w_load, w_queued, w_txd;

`ifdef UART_TX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 w_empty, w_full, w_wr, w_rd;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_ready  = r_rst_done && !w_full;
    assign w_push   = tx_valid && w_ready;
    assign w_avail  = !w_empty || w_push;
    assign w_queued = !w_empty;
    // An empty queue is bypassed so the start bit still follows the transfer edge by one clock.
    assign w_load_data = w_empty ? tx_data : r_mem[r_rd_ptr];
    assign w_wr        = w_push && !(w_load && w_empty);
    assign w_rd        = w_load && !w_empty;

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (w_wr) r_mem[r_wr_ptr] <= tx_data;
    end
`else
    logic w_unused_depth;

    // FIFO_DEPTH has no effect without the queue.
    assign w_unused_depth = ^FIFO_DEPTH;
    assign w_ready        = r_rst_done && (r_state == IDLE);
    assign w_push         = tx_valid && w_ready;
    assign w_avail        = w_push;
    assign w_queued       = 1'b0;
    assign w_load_data    = tx_data;
`endif

    uart_baud_tick #(
        .DIV (DIV),
        .CW  (CW)
    ) u_baud_tick (
        .clk_50M   (clk_50M),
        .reset_n   (reset_n),
        .i_restart (r_state == IDLE),
        .i_enable  (r_state != IDLE),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_avail) begin
                    w_state_nxt = START;
                    w_load      = 1'b1;
                end
            end
            START: begin
                if (w_tick) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_tick && r_bitcnt == LAST_DATA)
                    w_state_nxt = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (w_tick) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_tick && r_bitcnt == LAST_STOP) begin
                    if (w_avail) begin
                        w_state_nxt = START;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_state    <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_bitcnt <= '0;
            else if (w_tick && (r_state == DATA || r_state == STOP))
                r_bitcnt <= r_bitcnt + 1'b1;
            if (w_load) begin
                r_shift <= w_load_data;
                r_par   <= (PARITY_MODE == PARITY_ODD) ? ~^w_load_data : ^w_load_data;
            end else if (w_tick && r_state == DATA) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            START:   w_txd = 1'b0;
            DATA:    w_txd = r_shift[0];
            PARITY:  w_txd = r_par;
            default: w_txd = 1'b1;
        endcase
    end

    assign uart_txd = w_txd;
    assign tx_ready = w_ready;
    assign busy     = (r_state != IDLE) || w_queued;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: one default-rate instance plus fast-rate
// instances for parity, two-stop, reset and (with UART_TX_FIFO_EN) queue cases.
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] valid, ready, busy, txd;
    logic [8:0] data [5];
    int         n_assert = 0;
    int         n_fail   = 0;

    always #10 clk = ~clk;

    uart_tx_core u_def (
        .clk_50M(clk), .reset_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(ready[0]), .busy(busy[0]), .uart_txd(txd[0]));

    uart_tx_core #(.CLK_HZ(1600), .BAUD(100), .PARITY_MODE(2)) u_even (
        .clk_50M(clk), .reset_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(ready[1]), .busy(busy[1]), .uart_txd(txd[1]));

    uart_tx_core #(.CLK_HZ(1600), .BAUD(100), .PARITY_MODE(1)) u_odd (
        .clk_50M(clk), .reset_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
        .tx_ready(ready[2]), .busy(busy[2]), .uart_txd(txd[2]));

    uart_tx_core #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2)) u_stop2 (
        .clk_50M(clk), .reset_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
        .tx_ready(ready[3]), .busy(busy[3]), .uart_txd(txd[3]));

    uart_tx_core #(.CLK_HZ(1600), .BAUD(100)) u_fast (
        .clk_50M(clk), .reset_n(rst_n), .tx_valid(valid[4]), .tx_data(data[4][7:0]),
        .tx_ready(ready[4]), .busy(busy[4]), .uart_txd(txd[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walks one frame cycle by cycle starting at the negedge after its transfer edge.
    task automatic check_frame(input int sel, input logic [8:0] d, input int nd, input int pm,
                               input int ns, input int div, input int skip, input bit last,
                               input string tag);
        logic [12:0] exp;
        logic        p;
        int          nb, bad, rbad;
        exp = '1;
        p   = 1'b0;
        for (int i = 0; i < nd; i++) p = p ^ d[i];
        exp[0] = 1'b0;
        for (int i = 0; i < nd; i++) exp[1+i] = d[i];
        nb = 1 + nd;
        if (pm != 0) begin
            exp[nb] = (pm == 2) ? p : ~p;
            nb++;
        end
        nb = nb + ns;
        rbad = 0;
        for (int b = 0; b < nb; b++) begin
            bad = 0;
            for (int c = 0; c < div; c++) begin
                if (b * div + c >= skip) begin
                    if (txd[sel] !== exp[b]) bad++;
                    if (busy[sel] !== 1'b1) rbad++;
`ifndef UART_TX_FIFO_EN
                    if (ready[sel] !== 1'b0) rbad++;
`endif
                    data[sel] = 9'($urandom);
                    @(negedge clk);
                end
            end
            if (b * div + div > skip)
                chk($sformatf("%s_bit%0d_bad_cycles", tag, b), bad, 0);
        end
        chk({tag, "_busy_ready_in_frame"}, rbad, 0);
        if (last) begin
            chk({tag, "_end_txd"}, txd[sel], 1);
            chk({tag, "_end_busy"}, busy[sel], 0);
            chk({tag, "_end_ready"}, ready[sel], 1);
        end
    endtask

    task automatic send(input int sel, input logic [8:0] d, input int nd, input int pm,
                        input int ns, input int div, input string tag);
        valid[sel] = 1'b1;
        data[sel]  = d;
        chk({tag, "_ready_before"}, ready[sel], 1);
        @(negedge clk);
        valid[sel] = 1'b0;
        check_frame(sel, d, nd, pm, ns, div, 0, 1'b1, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = '0;
        for (int i = 0; i < 5; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_txd", txd, 5'h1F);
        chk("reset_busy", busy, 5'h00);
        chk("reset_ready", ready, 5'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready", ready, 5'h1F);
        chk("release_busy", busy, 5'h00);

        send(0, 9'h055, 8, 0, 1, 5208, "def_55");
        send(1, 9'h007, 8, 2, 1, 16, "even_07");
        send(2, 9'h007, 8, 1, 1, 16, "odd_07");
        send(3, 9'h07F, 7, 0, 2, 16, "stop2_7f");

        // Reset during data bit 3 (frame cycles 64..79) of an all-zero byte.
        valid[4] = 1'b1;
        data[4]  = 9'h000;
        chk("rst_ready_before", ready[4], 1);
        @(negedge clk);
        valid[4] = 1'b0;
        repeat (70) begin
            data[4] = 9'($urandom);
            @(negedge clk);
        end
        chk("rst_pre_txd", txd[4], 0);
        chk("rst_pre_busy", busy[4], 1);
        #5 rst_n = 1'b0;
        #1;
        chk("rst_now_txd", txd[4], 1);
        chk("rst_now_busy", busy[4], 0);
        chk("rst_now_ready", ready[4], 0);
        @(negedge clk);
        chk("rst_hold_txd", txd[4], 1);
        chk("rst_hold_ready", ready[4], 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_ready", ready[4], 1);
        chk("rst_after_txd", txd[4], 1);
        chk("rst_after_busy", busy[4], 0);
        send(4, 9'h0A3, 8, 0, 1, 16, "after_rst_a3");

`ifdef UART_TX_FIFO_EN
        begin : fifo_test
            logic [8:0] fb [6];
            fb[0] = 9'h011; fb[1] = 9'h02C; fb[2] = 9'h03A;
            fb[3] = 9'h047; fb[4] = 9'h05E; fb[5] = 9'h069;
            valid[4] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                data[4] = fb[k];
                chk($sformatf("fifo_ready_clk%0d", k), ready[4], (k < 5) ? 1 : 0);
                @(negedge clk);
            end
            valid[4] = 1'b0;
            check_frame(4, fb[0], 8, 0, 1, 16, 5, 1'b0, "fifo_f0");
            for (int k = 1; k < 5; k++)
                check_frame(4, fb[k], 8, 0, 1, 16, 0, (k == 4), $sformatf("fifo_f%0d", k));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
